// File: rtl/register_file_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between clients A and B.
// Define RF_ARB_CLEAR_EN to compile in the clear_req port and the zero-fill sweep.
module register_file_write_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          a_valid,
    input  logic [AW-1:0] a_sel,
    input  logic [DW-1:0] a_dat,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_sel,
    input  logic [DW-1:0] b_dat,
    output logic          b_ready,
`ifdef RF_ARB_CLEAR_EN
    input  logic          clear_req,
`endif
    output logic          busy,
    output logic          rf_WEN,
    output logic [AW-1:0] rf_wsel,
    output logic [DW-1:0] rf_wdat,
    output logic          last_grant
);

    // Highest register index; NREG == 2**AW so this is also the select mask.
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic          ptr_q, ptr_d;
    logic          last_grant_q, last_grant_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] wsel_q, wsel_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          arb_open;
    logic          a_fire, b_fire;

`ifdef RF_ARB_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // A pending clear request wins over both clients in the cycle it is seen.
    assign arb_open = !RST && (state_q == ST_IDLE) && !clear_req;
    assign busy     = (state_q == ST_CLEAR);
`else
    assign arb_open = !RST;
    assign busy     = 1'b0;
`endif

    assign a_ready = arb_open && a_valid && (!b_valid || (ptr_q == 1'b0));
    assign b_ready = arb_open && b_valid && (!a_valid || (ptr_q == 1'b1));
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    always_comb begin
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        wen_d        = 1'b0;
        wsel_d       = wsel_q;
        wdat_d       = wdat_q;

        // Register 0 is hardwired to zero: the handshake completes but no write is issued.
        if (a_fire) begin
            ptr_d        = 1'b1;
            last_grant_d = 1'b0;
            wsel_d       = a_sel & LAST_IDX;
            wdat_d       = a_dat;
            wen_d        = (a_sel != '0);
        end else if (b_fire) begin
            ptr_d        = 1'b0;
            last_grant_d = 1'b1;
            wsel_d       = b_sel & LAST_IDX;
            wdat_d       = b_dat;
            wen_d        = (b_sel != '0);
        end

`ifdef RF_ARB_CLEAR_EN
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = AW'(1);
                    wen_d   = 1'b1;
                    wsel_d  = AW'(1);
                    wdat_d  = '0;
                end
            end
            ST_CLEAR: begin
                // idx_q is the register being written this cycle; queue up the next one.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d  = idx_q + AW'(1);
                    wen_d  = 1'b1;
                    wsel_d = idx_q + AW'(1);
                    wdat_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q        <= 1'b0;
            last_grant_q <= 1'b0;
            wen_q        <= 1'b0;
            wsel_q       <= '0;
            wdat_q       <= '0;
`ifdef RF_ARB_CLEAR_EN
            state_q      <= ST_IDLE;
            idx_q        <= '0;
`endif
        end else begin
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            wsel_q       <= wsel_d;
            wdat_q       <= wdat_d;
`ifdef RF_ARB_CLEAR_EN
            state_q      <= state_d;
            idx_q        <= idx_d;
`endif
        end
    end

    assign rf_WEN     = wen_q;
    assign rf_wsel    = wsel_q;
    assign rf_wdat    = wdat_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Randomized bench for register_file_write_arbiter against a rule-level reference model.
// Clear-sweep scenarios are included when RF_ARB_CLEAR_EN is defined.
module tb_register_file_write_arbiter;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef RF_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_sel = '0;
    logic [DW-1:0] a_dat = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_sel = '0;
    logic [DW-1:0] b_dat = '0;
    logic          b_ready;
`ifdef RF_ARB_CLEAR_EN
    logic          clear_req = 1'b0;
`endif
    logic          busy;
    logic          rf_WEN;
    logic [AW-1:0] rf_wsel;
    logic [DW-1:0] rf_wdat;
    logic          last_grant;

    register_file_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .a_valid    (a_valid),
        .a_sel      (a_sel),
        .a_dat      (a_dat),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_sel      (b_sel),
        .b_dat      (b_dat),
        .b_ready    (b_ready),
`ifdef RF_ARB_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .busy       (busy),
        .rf_WEN     (rf_WEN),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .last_grant (last_grant)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who won last (-1 = nobody since reset), sweep position, expected outputs.
    int            prev_win  = -1;
    int            sweep_pos = 0;
    logic          m_busy    = 1'b0;
    logic          m_wen     = 1'b0;
    logic [AW-1:0] m_wsel    = '0;
    logic [DW-1:0] m_wdat    = '0;
    logic          m_lg      = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered at a falling edge; drives one cycle of inputs and checks both the
    // combinational readies and the registered outputs of the following cycle.
    task automatic step(input logic rst, input logic av, input logic [AW-1:0] asel,
                        input logic [DW-1:0] adat, input logic bv, input logic [AW-1:0] bsel,
                        input logic [DW-1:0] bdat, input logic cr);
        int   win;
        logic ear;
        logic ebr;
        RST     = rst;
        a_valid = av;
        a_sel   = asel;
        a_dat   = adat;
        b_valid = bv;
        b_sel   = bsel;
        b_dat   = bdat;
`ifdef RF_ARB_CLEAR_EN
        clear_req = cr;
`endif
        #1;
        win = -1;
        ear = 1'b0;
        ebr = 1'b0;
        if (rst) begin
            prev_win  = -1;
            sweep_pos = 0;
            m_busy    = 1'b0;
            m_wen     = 1'b0;
            m_wsel    = '0;
            m_wdat    = '0;
            m_lg      = 1'b0;
        end else if (m_busy) begin
            if (sweep_pos == NREG - 1) begin
                m_busy    = 1'b0;
                m_wen     = 1'b0;
                sweep_pos = 0;
            end else begin
                sweep_pos = sweep_pos + 1;
                m_wen     = 1'b1;
                m_wsel    = AW'(sweep_pos);
                m_wdat    = '0;
            end
        end else if (cr && CLR_EN) begin
            sweep_pos = 1;
            m_busy    = 1'b1;
            m_wen     = 1'b1;
            m_wsel    = AW'(1);
            m_wdat    = '0;
        end else begin
            if (av && bv) win = (prev_win == 0) ? 1 : 0;
            else if (av)  win = 0;
            else if (bv)  win = 1;
            m_wen = 1'b0;
            if (win == 0) begin
                ear = 1'b1; m_wen = (asel != 0); m_wsel = asel; m_wdat = adat; m_lg = 1'b0;
            end else if (win == 1) begin
                ebr = 1'b1; m_wen = (bsel != 0); m_wsel = bsel; m_wdat = bdat; m_lg = 1'b1;
            end
            if (win >= 0) prev_win = win;
        end
        chk("a_ready", 32'(a_ready), 32'(ear));
        chk("b_ready", 32'(b_ready), 32'(ebr));
        @(posedge CLK);
        @(negedge CLK);
        chk("rf_WEN", 32'(rf_WEN), 32'(m_wen));
        chk("rf_wsel", 32'(rf_wsel), 32'(m_wsel));
        chk("rf_wdat", rf_wdat, m_wdat);
        chk("last_grant", 32'(last_grant), 32'(m_lg));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic idle_step(input logic rst);
        step(rst, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        @(negedge CLK);
        // Reset with both clients requesting: no readies, outputs at reset values.
        step(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, 1'b0);
        step(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222, 1'b0);

        // Both valid right after reset: A, B, A, B.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'd1, 32'hA0 + 32'(i), 1'b1, 5'd2, 32'hB0 + 32'(i), 1'b0);

        // Fresh reset, then A alone.
        idle_step(1'b1);
        step(1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, '0, '0, 1'b0);
        // B writes register 0: handshake only, no write enable; A favoured afterwards.
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFF, 1'b0);
        idle_step(1'b0);
        step(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0);
        // A drops valid while B is held, then B alone.
        step(1'b0, 1'b0, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);

        if (CLR_EN) begin
            // Clear pulse while A requests; A keeps requesting through the sweep.
            step(1'b0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, '0, '0, 1'b1);
            for (int i = 0; i < NREG + 2; i++)
                step(1'b0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, '0, '0, (i % 3) == 0);
            // Reset in the middle of a sweep, then a restart from register 1.
            step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
            for (int i = 0; i < 9; i++) idle_step(1'b0);
            idle_step(1'b1);
            idle_step(1'b0);
            step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
            for (int i = 0; i < 4; i++) idle_step(1'b0);
            idle_step(1'b1);
        end

        // Both clients hammering with random selects.
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b1, AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                 1'b1, AW'($urandom_range(0, NREG - 1)), DW'($urandom), 1'b0);

        // Fully random traffic with occasional resets and clear requests.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom),
                 $urandom_range(0, 39) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
